// File: rtl/image_frame_loader.sv
// Streams one label byte plus a full pixel frame into the CNN input registers.
// Launches the CNN, then waits for its done edge before accepting the next frame.
module image_frame_loader #(
    parameter int IMG_PIXELS  = 784,
    parameter int PIX_W       = 8,
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIX_W-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    input  logic                        cnn_done,
    output logic [PIX_W*IMG_PIXELS-1:0] image_data,
    output logic [7:0]                  label,
    output logic                        start,
    output logic                        busy,
    output logic                        label_err,
    output logic [CNT_W-1:0]            frames_done
);

    localparam int PIX_CW = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam logic [PIX_CW-1:0] LAST_PIX = PIX_CW'(IMG_PIXELS - 1);
    localparam logic [PIX_W-1:0] CLS_LIM = PIX_W'(NUM_CLASSES);

    typedef enum logic [1:0] {
        GET_LABEL,
        GET_PIX,
        LAUNCH,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [PIX_CW-1:0] pix_cnt;
    logic              bad;
    logic              done_q;
    logic              accept;
    logic              done_rise;

    // flush blocks the byte on the same cycle so it is held upstream
    assign in_ready  = ((state == GET_LABEL) || (state == GET_PIX)) && !flush;
    assign accept    = in_valid && in_ready;
    assign done_rise = cnn_done && !done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= GET_LABEL;
            image_data  <= '0;
            label       <= '0;
            pix_cnt     <= '0;
            bad         <= 1'b0;
            done_q      <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            label_err   <= 1'b0;
            frames_done <= '0;
        end else begin
            start     <= 1'b0;
            label_err <= 1'b0;
            done_q    <= cnn_done;
            if (flush) begin
                state   <= GET_LABEL;
                pix_cnt <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    GET_LABEL: begin
                        if (accept) begin
                            label   <= 8'(in_data);
                            pix_cnt <= '0;
                            bad     <= (in_data >= CLS_LIM);
                            state   <= GET_PIX;
                        end
                    end
                    GET_PIX: begin
                        if (accept) begin
                            image_data[pix_cnt*PIX_W +: PIX_W] <= in_data;
                            pix_cnt <= pix_cnt + 1'b1;
                            if (pix_cnt == LAST_PIX) begin
                                pix_cnt <= '0;
                                // an illegal label drops the frame silently apart from the error pulse
                                if (bad) begin
                                    label_err <= 1'b1;
                                    state     <= GET_LABEL;
                                end else begin
                                    start <= 1'b1;
                                    state <= LAUNCH;
                                end
                            end
                        end
                    end
                    LAUNCH: begin
                        busy  <= 1'b1;
                        state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        // a level left high by the previous frame is not a new completion
                        if (done_rise) begin
                            busy        <= 1'b0;
                            frames_done <= frames_done + 1'b1;
                            state       <= GET_LABEL;
                        end
                    end
                    default: state <= GET_LABEL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// Randomised stream bench for image_frame_loader with a frame-level reference model.
// A second small instance exercises frames_done wrap-around in few cycles.
module tb_image_frame_loader;

    localparam int NPIX = 784;
    localparam int PW   = 8;
    localparam int CW   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 flush = 1'b0;
    logic                 cnn_done = 1'b0;
    logic                 in_ready;
    logic [PW*NPIX-1:0]   image_data;
    logic [7:0]           label;
    logic                 start;
    logic                 busy;
    logic                 label_err;
    logic [CW-1:0]        frames_done;

    logic                 w_rst = 1'b1;
    logic [7:0]           w_in_data = '0;
    logic                 w_in_valid = 1'b0;
    logic                 w_flush = 1'b0;
    logic                 w_cnn_done = 1'b0;
    logic                 w_in_ready;
    logic [31:0]          w_image_data;
    logic [7:0]           w_label;
    logic                 w_start;
    logic                 w_busy;
    logic                 w_label_err;
    logic [2:0]           w_frames_done;

    image_frame_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .cnn_done(cnn_done),
        .image_data(image_data), .label(label), .start(start), .busy(busy),
        .label_err(label_err), .frames_done(frames_done)
    );

    image_frame_loader #(.IMG_PIXELS(4), .PIX_W(8), .NUM_CLASSES(10), .CNT_W(3)) dut_w (
        .clk(clk), .rst(w_rst), .in_data(w_in_data), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .flush(w_flush), .cnn_done(w_cnn_done),
        .image_data(w_image_data), .label(w_label), .start(w_start), .busy(w_busy),
        .label_err(w_label_err), .frames_done(w_frames_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame-level view of the stream
    int               m_cnt = 0;      // bytes of current frame taken (0 = label next)
    bit               m_launch = 0;
    bit               m_wait = 0;
    bit               m_busy = 0;
    bit               m_lerr = 0;
    bit               m_bad = 0;
    bit               m_dprev = 0;
    logic [CW-1:0]    m_frames = '0;
    logic [7:0]       m_label = '0;
    logic [PW*NPIX-1:0] m_img = '0;

    always @(posedge clk or posedge rst) begin
        bit rdy, acc, rise, was_launch;
        if (rst) begin
            m_cnt = 0; m_launch = 0; m_wait = 0; m_busy = 0; m_lerr = 0;
            m_bad = 0; m_dprev = 0; m_frames = '0; m_label = '0; m_img = '0;
        end else begin
            rdy = !m_launch && !m_wait && !flush;
            acc = in_valid && rdy;
            rise = cnn_done && !m_dprev;
            m_dprev = cnn_done;
            m_lerr = 0;
            was_launch = m_launch;
            m_launch = 0;
            if (flush) begin
                m_cnt = 0; m_wait = 0; m_busy = 0;
            end else if (was_launch) begin
                m_wait = 1; m_busy = 1;
            end else if (m_wait) begin
                if (rise) begin
                    m_wait = 0; m_busy = 0; m_frames = m_frames + 1'b1;
                end
            end else if (acc) begin
                if (m_cnt == 0) begin
                    m_label = in_data;
                    m_bad = (in_data >= 8'd10);
                    m_cnt = 1;
                end else begin
                    m_img[(m_cnt-1)*PW +: PW] = in_data;
                    m_cnt++;
                    if (m_cnt == NPIX + 1) begin
                        m_cnt = 0;
                        if (m_bad) m_lerr = 1;
                        else m_launch = 1;
                    end
                end
            end
        end
    end

    int acc_cnt = 0;
    int start_cnt = 0;
    int lerr_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, !m_launch && !m_wait && !flush);
            chk("start", start, m_launch);
            chk("busy", busy, m_busy);
            chk("label_err", label_err, m_lerr);
            chk("frames_done", frames_done, m_frames);
            chk("label", label, m_label);
            total++;
            if (image_data !== m_img) begin
                int k;
                bad++;
                for (k = 0; k < NPIX; k++)
                    if (image_data[k*PW +: PW] !== m_img[k*PW +: PW]) break;
                $display("FAIL image pixel %0d: got %0h expected %0h",
                         k, image_data[k*PW +: PW], m_img[k*PW +: PW]);
            end
            if (in_valid && in_ready) acc_cnt++;
            if (start) start_cnt++;
            if (label_err) lerr_cnt++;
        end
    end

    // CNN stand-in: clears done on start, raises it after a random delay
    bit resp_en = 0;
    initial forever begin
        @(negedge clk);
        if (resp_en && start) begin
            @(posedge clk);
            #1 cnn_done = 1'b0;
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 cnn_done = 1'b1;
        end
    end

    bit rdy_s;
    logic [7:0] first_pix;

    task automatic step();
        @(negedge clk);
        rdy_s = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        do begin
            step();
            n++;
        end while (!rdy_s && n < 3000);
        if (!rdy_s) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte %0h not taken after %0d cycles", b, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] lbl, input bit rnd, input int npix, input int gap);
        logic [7:0] p;
        send_byte(lbl, gap);
        for (int k = 0; k < npix; k++) begin
            p = rnd ? 8'($urandom) : 8'(k);
            if (k == 0) first_pix = p;
            send_byte(p, gap);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || start) && n < 500);
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, n);
        end
    endtask

    task automatic w_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, sc, lc, e;
        cnn_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_label", label, 0);
        chk("rst_image_zero", image_data == '0, 1);
        rst = 1'b0;
        w_rst = 1'b0;

        // ramp frame, continuous valid, stale done left high
        a0 = acc_cnt;
        send_frame(8'd3, 1'b0, NPIX, 0);
        chk("t1_start", start, 1);
        chk("t1_accepts", acc_cnt - a0, 785);
        chk("t1_label", label, 3);
        chk("t1_pix0", image_data[0 +: 8], 8'h00);
        chk("t1_pix300", image_data[300*8 +: 8], 8'h2c);
        chk("t1_pix783", image_data[783*8 +: 8], 8'h0f);
        step();
        chk("t1_busy", busy, 1);
        chk("t1_start_gone", start, 0);
        chk("t1_ready_low", in_ready, 0);

        // stale high level must not complete; only the fresh rise does
        repeat (3) step();
        chk("t2_stale_busy", busy, 1);
        chk("t2_stale_frames", frames_done, 0);
        cnn_done = 1'b0;
        repeat (2) step();
        chk("t2_low_busy", busy, 1);
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        chk("t2_busy_fall", busy, 0);
        chk("t2_frames", frames_done, 1);
        chk("t2_ready", in_ready, 1);

        // illegal label drops the frame
        lc = lerr_cnt;
        sc = start_cnt;
        send_frame(8'd12, 1'b1, NPIX, 0);
        step();
        step();
        chk("t3_lerr_once", lerr_cnt - lc, 1);
        chk("t3_no_start", start_cnt - sc, 0);
        chk("t3_frames", frames_done, 1);
        resp_en = 1;
        send_frame(8'd7, 1'b1, NPIX, 0);
        wait_idle();
        chk("t3_next_frames", frames_done, 2);
        chk("t3_next_label", label, 7);

        // flush mid-frame, presented byte dropped
        sc = start_cnt;
        send_frame(8'd5, 1'b1, 400, 0);
        in_valid = 1'b1;
        in_data = 8'haa;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("t4_no_start", start_cnt - sc, 0);
        send_frame(8'd1, 1'b1, NPIX, 0);
        chk("t4_pix0", image_data[0 +: 8], first_pix);
        chk("t4_label", label, 1);
        wait_idle();
        chk("t4_one_start", start_cnt - sc, 1);
        chk("t4_frames", frames_done, 3);

        // gappy back-to-back frames, next label held during WAIT_DONE
        for (int f = 0; f < 3; f++)
            send_frame(8'($urandom_range(0, 9)), 1'b1, NPIX, 50);
        wait_idle();
        chk("t5_frames", frames_done, 6);

        // async reset mid-frame
        resp_en = 0;
        send_frame(8'd4, 1'b1, 500, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_start", start, 0);
        chk("t6_rst_lerr", label_err, 0);
        chk("t6_rst_frames", frames_done, 0);
        chk("t6_rst_label", label, 0);
        chk("t6_rst_image_zero", image_data == '0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        sc = start_cnt;
        repeat (5) step();
        chk("t6_no_start", start_cnt - sc, 0);

        // frames_done wrap on the small instance
        for (int i = 0; i < 9; i++) begin
            w_in_valid = 1'b1;
            w_in_data = 8'd2;
            w_step();
            for (int p = 0; p < 4; p++) begin
                w_in_data = 8'(i*4 + p + 1);
                w_step();
            end
            w_in_valid = 1'b0;
            chk("w_start", w_start, 1);
            w_step();
            w_cnn_done = 1'b1;
            w_step();
            e = (i + 1) % 8;
            chk("w_busy_fall", w_busy, 0);
            chk("w_frames", w_frames_done, e);
            w_cnn_done = 1'b0;
            w_step();
        end
        chk("w_wrapped_count", w_frames_done, 1);
        chk("w_last_pix3", w_image_data[3*8 +: 8], 8'd36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
